// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_GO      = 3'd3,
    ST_MEASURE = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int          RESULT_W  = 14;

  // Saturate a millisecond count at limit and narrow it to the result width.
  function automatic logic [RESULT_W-1:0] clamp_ms(input logic [31:0] ms,
                                                   input logic [31:0] limit);
    return RESULT_W'((ms < limit) ? ms : limit);
  endfunction

  // One right shift of the Galois LFSR; the feedback mask is applied when bit 0 falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_ctrl_if.sv
// Button, ms-counter and result signals of reaction_ctrl.
// best_ms exists only when REACTION_BEST_EN is defined.
interface reaction_ctrl_if;
  import reaction_pkg::*;

  logic                start_btn;
  logic                react_btn;
  logic [31:0]         ms_passed;
  logic                cnt_en;
  logic                cnt_rst;
  logic                stim_led;
  logic [RESULT_W-1:0] result_ms;
  logic                result_valid;
  logic                false_start;
  logic                timeout;
  logic [2:0]          state_o;
`ifdef REACTION_BEST_EN
  logic [RESULT_W-1:0] best_ms;

  modport master (output start_btn, react_btn, ms_passed,
                  input  cnt_en, cnt_rst, stim_led, result_ms, result_valid,
                         false_start, timeout, state_o, best_ms);
  modport slave  (input  start_btn, react_btn, ms_passed,
                  output cnt_en, cnt_rst, stim_led, result_ms, result_valid,
                         false_start, timeout, state_o, best_ms);
`else
  modport master (output start_btn, react_btn, ms_passed,
                  input  cnt_en, cnt_rst, stim_led, result_ms, result_valid,
                         false_start, timeout, state_o);
  modport slave  (input  start_btn, react_btn, ms_passed,
                  output cnt_en, cnt_rst, stim_led, result_ms, result_valid,
                         false_start, timeout, state_o);
`endif
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR supplying the random part of the pre-stimulus delay.
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  // Shift every cycle; the non-zero seed keeps the sequence off the all-zero lock-up state.
  always_ff @(posedge clk) begin
    if (rst) q <= LFSR_SEED;
    else     q <= lfsr_next(q);
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: random delay, stimulus lamp, reaction measurement.
// Optional feature macro: REACTION_BEST_EN adds the best_ms output (best valid reaction time).
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 11,
  parameter int unsigned TIMEOUT_MS   = 9999
) (
  input logic            clk,
  input logic            rst,
  reaction_ctrl_if.slave bus
);

  localparam logic [31:0] MIN_L     = 32'(MIN_DELAY_MS);
  localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT_MS);
  localparam logic [15:0] RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);

  state_t              state, state_nxt;
  logic                start_q, react_q;
  logic                start_rise, react_rise;
  logic [15:0]         lfsr_q;
  logic [31:0]         delay_tgt, delay_nxt;
  logic [RESULT_W-1:0] result_ms, res_nxt;
  logic                result_valid, valid_nxt;
  logic                false_start, fs_nxt;
  logic                timeout, to_nxt;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign start_rise = bus.start_btn & ~start_q;
  assign react_rise = bus.react_btn & ~react_q;

  // State, delay target, round results and button history; buttons load 1 on reset so a held press is no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      start_q      <= 1'b1;
      react_q      <= 1'b1;
      delay_tgt    <= 32'd0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nxt;
      start_q      <= bus.start_btn;
      react_q      <= bus.react_btn;
      delay_tgt    <= delay_nxt;
      result_ms    <= res_nxt;
      result_valid <= valid_nxt;
      false_start  <= fs_nxt;
      timeout      <= to_nxt;
    end
  end

  // Next-state and result update; a reaction press beats a simultaneous delay expiry or timeout.
  always_comb begin
    state_nxt = state;
    delay_nxt = delay_tgt;
    res_nxt   = result_ms;
    valid_nxt = result_valid;
    fs_nxt    = false_start;
    to_nxt    = timeout;
    case (state)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start_rise) state_nxt = ST_ARM;
        else            state_nxt = state;
      end
      ST_ARM: begin
        delay_nxt = MIN_L + {16'h0000, lfsr_q & RAND_MASK};
        valid_nxt = 1'b0;
        fs_nxt    = 1'b0;
        to_nxt    = 1'b0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (react_rise) begin
          fs_nxt    = 1'b1;
          state_nxt = ST_FAULT;
        end else if (bus.ms_passed >= delay_tgt) begin
          state_nxt = ST_GO;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_GO: begin
        state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (react_rise) begin
          res_nxt   = clamp_ms(bus.ms_passed, TIMEOUT_L);
          valid_nxt = 1'b1;
          state_nxt = ST_DONE;
        end else if (bus.ms_passed >= TIMEOUT_L) begin
          res_nxt   = RESULT_W'(TIMEOUT_L);
          to_nxt    = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_MEASURE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.cnt_rst      = (state == ST_ARM)  || (state == ST_GO);
  assign bus.cnt_en       = (state == ST_WAIT) || (state == ST_MEASURE);
  assign bus.stim_led     = (state == ST_GO)   || (state == ST_MEASURE);
  assign bus.state_o      = state;
  assign bus.result_ms    = result_ms;
  assign bus.result_valid = result_valid;
  assign bus.false_start  = false_start;
  assign bus.timeout      = timeout;

`ifdef REACTION_BEST_EN
  logic [RESULT_W-1:0] best_ms;
  logic                best_upd;

  // Only a real press reaches DONE with timeout clear, so this is exactly the non-timeout DONE entry.
  assign best_upd = (state == ST_MEASURE) && react_rise && (res_nxt < best_ms);

  // Best reaction survives rounds; only reset restores the all-ones "no result yet" value.
  always_ff @(posedge clk) begin
    if (rst)           best_ms <= {RESULT_W{1'b1}};
    else if (best_upd) best_ms <= res_nxt;
    else               best_ms <= best_ms;
  end

  assign bus.best_ms = best_ms;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl (MIN_DELAY_MS=2, RAND_BITS=2, TIMEOUT_MS=20).
// best_ms checks are compiled only when REACTION_BEST_EN is defined.
module tb_reaction_ctrl;

  localparam int MIN_MS  = 2;
  localparam int TO_MS   = 20;
  localparam logic [15:0] LOW_MASK = 16'h0003;

  typedef struct {
    logic [2:0]  arm_state;
    int          tgt;
    bit          saw_led_wait;
    int          wait_exit_ms;
    int          meas_exit_ms;
    logic [2:0]  end_state;
    logic [13:0] res;
    logic        valid;
    logic        fs;
    logic        to;
    logic        led_end;
    bit          hung;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ms_cnt = 32'd0;
  logic [15:0] m_lfsr = 16'h0000;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [13:0] exp_res;

  reaction_ctrl_if bus();

  reaction_ctrl #(.MIN_DELAY_MS(2), .RAND_BITS(2), .TIMEOUT_MS(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural external ms counter: one "ms" per clock while enabled.
  always @(posedge clk) begin
    if (bus.cnt_rst)     ms_cnt <= 32'd0;
    else if (bus.cnt_en) ms_cnt <= ms_cnt + 32'd1;
  end
  assign bus.ms_passed = ms_cnt;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference copy of the random source, reseeded by reset and stepped every clock.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays one round. early: press while waiting at press_ms (negative = at the delay target).
  // press: press while measuring at press_ms. want_low >= 0 aligns the start with that LFSR value.
  task automatic play_round(input bit early, input bit press, input int press_ms,
                            input int want_low, input bit poke, output obs_t o);
    int n;
    int pm;
    int ms;
    logic [2:0] st;
    o = '{default: 0};
    o.wait_exit_ms = -1;
    o.meas_exit_ms = -1;
    o.hung = 1'b1;
    if (want_low >= 0) begin
      n = 0;
      while (int'(lfsr_step(m_lfsr) & LOW_MASK) != want_low && n < 100) begin
        tick();
        n++;
      end
    end
    bus.start_btn = 1'b1;
    tick();
    o.arm_state = bus.state_o;
    o.tgt = MIN_MS + int'(m_lfsr & LOW_MASK);
    bus.start_btn = 1'b0;
    pm = (press_ms < 0) ? o.tgt : press_ms;
    n = 0;
    while (n < 200) begin
      st = bus.state_o;
      ms = int'(bus.ms_passed);
      if (st == 3'd5 || st == 3'd6) begin
        o.hung = 1'b0;
        break;
      end
      if (st == 3'd2) begin
        o.wait_exit_ms = ms;
        if (bus.stim_led) o.saw_led_wait = 1'b1;
        if (early && ms == pm) bus.react_btn = 1'b1;
      end
      if (st == 3'd4) begin
        o.meas_exit_ms = ms;
        if (!early && press && ms == pm) bus.react_btn = 1'b1;
      end
      if (poke && (st == 3'd2 || st == 3'd3 || st == 3'd4)) bus.start_btn = n[0];
      tick();
      n++;
    end
    o.end_state = bus.state_o;
    o.res       = bus.result_ms;
    o.valid     = bus.result_valid;
    o.fs        = bus.false_start;
    o.to        = bus.timeout;
    o.led_end   = bus.stim_led;
    bus.start_btn = 1'b0;
    bus.react_btn = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_btn = 1'b1;
    bus.react_btn = 1'b0;
    tick();
    tick();
    n_tests++; if (bus.state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state_o); end
    n_tests++; if (bus.result_ms !== 14'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", bus.result_ms); end
    n_tests++; if ({bus.result_valid, bus.false_start, bus.timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.result_valid, bus.false_start, bus.timeout}); end
    n_tests++; if ({bus.stim_led, bus.cnt_en, bus.cnt_rst} !== 3'b000) begin n_fail++; $display("FAIL reset_moore: got %b expected 000", {bus.stim_led, bus.cnt_en, bus.cnt_rst}); end
    rst = 1'b0;
    tick();
    tick();
    tick();
    n_tests++; if (bus.state_o !== 3'd0) begin n_fail++; $display("FAIL held_start: got %0d expected 0", bus.state_o); end
    bus.start_btn = 1'b0;
    tick();
    exp_res = 14'd0;
  endtask

  task automatic test_normal();
    obs_t o;
    play_round(1'b0, 1'b1, 7, 1, 1'b0, o);
    n_tests++; if (o.hung) begin n_fail++; $display("FAIL normal_hang: got hung expected DONE"); end
    n_tests++; if (o.arm_state !== 3'd1) begin n_fail++; $display("FAIL normal_arm: got %0d expected 1", o.arm_state); end
    n_tests++; if (o.wait_exit_ms != 3) begin n_fail++; $display("FAIL normal_delay: got %0d expected 3", o.wait_exit_ms); end
    n_tests++; if (o.saw_led_wait) begin n_fail++; $display("FAIL normal_led_wait: got 1 expected 0"); end
    n_tests++; if ({o.end_state, o.res} !== {3'd5, 14'd7}) begin n_fail++; $display("FAIL normal_result: got state %0d ms %0d expected state 5 ms 7", o.end_state, o.res); end
    n_tests++; if ({o.valid, o.fs, o.to} !== 3'b100) begin n_fail++; $display("FAIL normal_flags: got %b expected 100", {o.valid, o.fs, o.to}); end
    exp_res = 14'd7;
  endtask

  task automatic test_false_start();
    obs_t o;
    play_round(1'b1, 1'b0, 1, -1, 1'b0, o);
    n_tests++; if (o.end_state !== 3'd6) begin n_fail++; $display("FAIL false_state: got %0d expected 6", o.end_state); end
    n_tests++; if ({o.valid, o.fs, o.to} !== 3'b010) begin n_fail++; $display("FAIL false_flags: got %b expected 010", {o.valid, o.fs, o.to}); end
    n_tests++; if (o.saw_led_wait || o.led_end) begin n_fail++; $display("FAIL false_led: got 1 expected 0"); end
    n_tests++; if (o.res !== exp_res) begin n_fail++; $display("FAIL false_hold: got %0d expected %0d", o.res, exp_res); end
  endtask

  task automatic test_timeout();
    obs_t o;
    play_round(1'b0, 1'b0, 0, -1, 1'b0, o);
    n_tests++; if (o.meas_exit_ms != TO_MS) begin n_fail++; $display("FAIL timeout_exit: got %0d expected %0d", o.meas_exit_ms, TO_MS); end
    n_tests++; if ({o.end_state, o.res} !== {3'd5, 14'd20}) begin n_fail++; $display("FAIL timeout_result: got state %0d ms %0d expected state 5 ms 20", o.end_state, o.res); end
    n_tests++; if ({o.valid, o.fs, o.to} !== 3'b101) begin n_fail++; $display("FAIL timeout_flags: got %b expected 101", {o.valid, o.fs, o.to}); end
    exp_res = 14'd20;
  endtask

  task automatic test_simultaneous();
    obs_t o;
    play_round(1'b1, 1'b0, -1, -1, 1'b0, o);
    n_tests++; if ({o.end_state, o.fs, o.saw_led_wait} !== {3'd6, 1'b1, 1'b0}) begin n_fail++; $display("FAIL simul_wait: got state %0d fs %0d expected state 6 fs 1", o.end_state, o.fs); end
    play_round(1'b0, 1'b1, TO_MS, -1, 1'b0, o);
    n_tests++; if ({o.end_state, o.res} !== {3'd5, 14'd20}) begin n_fail++; $display("FAIL simul_meas: got state %0d ms %0d expected state 5 ms 20", o.end_state, o.res); end
    n_tests++; if ({o.valid, o.fs, o.to} !== 3'b100) begin n_fail++; $display("FAIL simul_flags: got %b expected 100", {o.valid, o.fs, o.to}); end
    exp_res = 14'd20;
  endtask

  // Random rounds with random presses and start pokes mid-round, checked against the game rules.
  task automatic test_random();
    obs_t o;
    int mode;
    int pm;
    bit poke;
    logic [2:0] e_state;
    logic e_valid, e_fs, e_to;
    int e_exit;
    for (int i = 0; i < 12; i++) begin
      mode = int'($urandom_range(0, 3));
      poke = 1'($urandom_range(0, 1));
      case (mode)
        0:       pm = int'($urandom_range(0, MIN_MS));
        1:       pm = int'($urandom_range(0, 19));
        2:       pm = int'($urandom_range(20, 24));
        default: pm = 0;
      endcase
      play_round(mode == 0, mode == 1 || mode == 2, pm, -1, poke, o);
      e_exit = TO_MS;
      if (mode == 0) begin
        e_state = 3'd6; e_valid = 1'b0; e_fs = 1'b1; e_to = 1'b0;
      end else if (mode != 3 && pm <= TO_MS) begin
        e_state = 3'd5; e_valid = 1'b1; e_fs = 1'b0; e_to = 1'b0;
        exp_res = 14'(pm); e_exit = pm;
      end else begin
        e_state = 3'd5; e_valid = 1'b1; e_fs = 1'b0; e_to = 1'b1;
        exp_res = 14'(TO_MS);
      end
      n_tests++; if (o.hung) begin n_fail++; $display("FAIL rnd_hang[%0d]: got hung expected end", i); end
      n_tests++;
      if ({o.end_state, o.res, o.valid, o.fs, o.to} !== {e_state, exp_res, e_valid, e_fs, e_to}) begin
        n_fail++;
        $display("FAIL rnd_result[%0d] mode %0d pm %0d: got st %0d ms %0d v%0d f%0d t%0d expected st %0d ms %0d v%0d f%0d t%0d",
                 i, mode, pm, o.end_state, o.res, o.valid, o.fs, o.to, e_state, exp_res, e_valid, e_fs, e_to);
      end
      if (mode != 0) begin
        n_tests++; if (o.wait_exit_ms != o.tgt) begin n_fail++; $display("FAIL rnd_delay[%0d]: got %0d expected %0d", i, o.wait_exit_ms, o.tgt); end
        n_tests++; if (o.meas_exit_ms != e_exit) begin n_fail++; $display("FAIL rnd_exit[%0d]: got %0d expected %0d", i, o.meas_exit_ms, e_exit); end
      end else begin
        n_tests++; if (o.saw_led_wait) begin n_fail++; $display("FAIL rnd_led[%0d]: got 1 expected 0", i); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    n = 0;
    while (bus.state_o !== 3'd4 && n < 100) begin tick(); n++; end
    n_tests++; if (bus.state_o !== 3'd4) begin n_fail++; $display("FAIL mid_reach: got %0d expected 4", bus.state_o); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_tests++; if (bus.state_o !== 3'd0) begin n_fail++; $display("FAIL mid_state: got %0d expected 0", bus.state_o); end
    n_tests++; if ({bus.stim_led, bus.cnt_en, bus.result_valid} !== 3'b000) begin n_fail++; $display("FAIL mid_outputs: got %b expected 000", {bus.stim_led, bus.cnt_en, bus.result_valid}); end
    n_tests++; if (bus.result_ms !== 14'd0) begin n_fail++; $display("FAIL mid_result: got %0d expected 0", bus.result_ms); end
    rst = 1'b0;
    tick();
    exp_res = 14'd0;
  endtask

`ifdef REACTION_BEST_EN
  task automatic test_best();
    obs_t o;
    int presses [3] = '{9, 5, 12};
    int bests [3]   = '{9, 5, 5};
    n_tests++; if (bus.best_ms !== 14'd16383) begin n_fail++; $display("FAIL best_reset: got %0d expected 16383", bus.best_ms); end
    for (int i = 0; i < 3; i++) begin
      play_round(1'b0, 1'b1, presses[i], -1, 1'b0, o);
      n_tests++; if (bus.best_ms !== 14'(bests[i])) begin n_fail++; $display("FAIL best_round[%0d]: got %0d expected %0d", i, bus.best_ms, bests[i]); end
    end
    play_round(1'b0, 1'b0, 0, -1, 1'b0, o);
    n_tests++; if (bus.best_ms !== 14'd5) begin n_fail++; $display("FAIL best_timeout: got %0d expected 5", bus.best_ms); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.start_btn = 1'b0;
    bus.react_btn = 1'b0;
    test_reset();
    test_normal();
    test_false_start();
    test_timeout();
    test_simultaneous();
    test_random();
    test_reset_mid();
`ifdef REACTION_BEST_EN
    test_best();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 Param MIN_DELAY_MS, default 1000: fixed part of the random pre-stimulus delay, in ms.
REQ-002 Param RAND_BITS, default 11: number of LFSR low bits added to MIN_DELAY_MS (range 0..2^RAND_BITS-1).
REQ-003 Param TIMEOUT_MS, default 9999: reaction timeout in ms; SHALL be at most 16383.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start_btn  in  1  debounced start level; only rising edges act.
REQ-007 react_btn  in  1  debounced reaction level; only rising edges act.
REQ-008 ms_passed  in  32  count from the external ms counter.
REQ-009 cnt_en  out  1  enable to the ms counter.
REQ-010 cnt_rst  out  1  clear to the ms counter.
REQ-011 stim_led  out  1  stimulus lamp.
REQ-012 result_ms  out  14  last reaction time in ms.
REQ-013 result_valid  out  1  result_ms holds a valid round result.
REQ-014 false_start  out  1  last round aborted by an early press.
REQ-015 timeout  out  1  last round hit TIMEOUT_MS.
REQ-016 state_o  out  3  current state encoding, for debug.

Function
REQ-017 Edge detect: rise = btn & ~btn_q; btn_q is registered every cycle.
REQ-018 State encodings: IDLE=0, ARM=1, WAIT=2, GO=3, MEASURE=4, DONE=5, FAULT=6.
REQ-019 Outputs: cnt_rst=1 in ARM and GO only; cnt_en=1 in WAIT and MEASURE only; stim_led=1 in GO and MEASURE only. All three decode the state register (Moore).
REQ-020 IDLE, DONE, FAULT: start rise -> ARM. All other inputs are ignored.
REQ-021 ARM (one cycle): latch delay_tgt = MIN_DELAY_MS + lfsr[RAND_BITS-1:0]; clear result_valid, false_start, timeout; then -> WAIT.
REQ-022 WAIT: react rise -> FAULT and set false_start. Otherwise ms_passed >= delay_tgt -> GO. If both occur in the same cycle, the react press wins.
REQ-023 GO (one cycle) -> MEASURE.
REQ-024 MEASURE: react rise -> DONE; result_ms = min(ms_passed, TIMEOUT_MS); result_valid=1.
REQ-025 MEASURE: ms_passed >= TIMEOUT_MS with no react rise -> DONE; result_ms = TIMEOUT_MS; timeout=1; result_valid=1. If both occur in the same cycle, the react press wins (timeout stays 0).
REQ-026 start rises during ARM, WAIT, GO or MEASURE SHALL be ignored.
REQ-027 result_ms, result_valid, false_start and timeout are registered and hold until the next ARM.
REQ-028 LFSR: 16-bit Galois, mask 0xB400, shifts right every clk cycle, never reaches zero.
REQ-029 Unencoded state values (7) SHALL return to IDLE on the next clock.

Reset
REQ-030 With rst=1 at a clock edge: state=IDLE, result_ms=0, result_valid=0, false_start=0, timeout=0, lfsr=0xACE1.
REQ-031 With rst=1 at a clock edge: btn_q registers load 1, so a button already held at reset release does not count as an edge.
REQ-032 Reset mid-round SHALL abort the round. stim_led and cnt_en are 0 in the first cycle after the reset edge.

Configuration
REQ-033 Macro REACTION_BEST_EN, when defined, adds output best_ms (out, 14 bits, best valid reaction time). It resets to 16383 and updates on entry to DONE when timeout=0 and result_ms < best_ms.
REQ-034 Without REACTION_BEST_EN, the best_ms port and its register are absent; all other behaviour is identical.

Structure
REQ-035 Package reaction_pkg holds the state enum (3-bit), LFSR_SEED=16'hACE1, LFSR_MASK=16'hB400, and RESULT_W=14.
REQ-036 The LFSR is a separate sub-module, lfsr16 (clk, rst, q[15:0]), instantiated once.

Verification
Bench parameters: MIN_DELAY_MS=2, RAND_BITS=2, TIMEOUT_MS=20. Bench drives ms_passed from a behavioural counter that obeys cnt_rst/cnt_en.
REQ-037 Normal round: start rise; lfsr low bits=1, so delay_tgt=3; react rise at ms_passed=7 in MEASURE -> result_ms=7, result_valid=1, false_start=0, timeout=0.
REQ-038 False start: react rise in WAIT at ms_passed=1 -> FAULT, false_start=1, stim_led never asserted.
REQ-039 Timeout: no react press -> DONE at ms_passed=20, result_ms=20, timeout=1.
REQ-040 Simultaneous: react rise in the same cycle as ms_passed reaches delay_tgt -> FAULT. React rise in the same cycle as ms_passed=20 in MEASURE -> result_ms=20, timeout=0.
REQ-041 rst=1 in MEASURE -> next cycle state_o=0, stim_led=0, cnt_en=0, result_valid=0. start held high through reset release -> stays in IDLE.
REQ-042 With REACTION_BEST_EN: rounds of 9, 5, 12 ms -> best_ms reads 16383, 9, 5, 5 after each DONE entry; a timeout round leaves best_ms=5.
